// File: rtl/snn_pkg.sv
// Shared types and width defaults for the SNN tile control slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package snn_pkg;

  // Default geometry of one neuron_tile and its memories.
  localparam int default_size_data    = 8;
  localparam int default_size_vmem    = 16;
  localparam int default_size_tile    = 4;
  localparam int default_num_inputs   = 16;
  localparam int default_size_addr    = 8;
  localparam int default_tile_latency = 2;

  // One weight row (all neurons of the tile) and one vmem word.
  localparam int weight_word_w = default_size_tile * default_size_data;
  localparam int vmem_word_w   = default_size_tile * default_size_vmem;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    RD_VMEM    = 4'd1,
    LATCH_VMEM = 4'd2,
    SCAN       = 4'd3,
    W_VALID    = 4'd4,
    FINISH     = 4'd5,
    WAIT_TILE  = 4'd6,
    WRITEBACK  = 4'd7,
    DONE       = 4'd8
  } seq_state_t;

endpackage

// File: rtl/lowest_set_encoder.sv
// Lowest-set-bit encoder: index of the least significant 1 in vec, plus valid.
// Latency: combinational.
// Backpressure: none.
// Ports: vec (in, width), idx (out, index of lowest set bit, 0 when none), valid (out, vec != 0).
module lowest_set_encoder #(
  parameter int width = 16,
  parameter int idx_w = (width > 1) ? $clog2(width) : 1
) (
  input  logic [width-1:0] vec,
  output logic [idx_w-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the last hit, which wins, is the lowest bit.
  always_comb begin
    idx   = '0;
    valid = |vec;
    for (int i = width - 1; i >= 0; i--) begin
      if (vec[i]) idx = idx_w'(i);
    end
  end

endmodule

// File: rtl/tile_event_sequencer.sv
// Per-timestep sequencer for one neuron_tile: vmem load, spike-driven weight fetches, drain, writeback.
// Latency: done pulses 6 + 2*k + tile_latency cycles after start is sampled (k = set spikes).
// Backpressure: none; memories answer in one fixed cycle, start is ignored while busy.
// Ports: start/inSpikes/weightBase/vmemAddr (timestep request), wMem* (weight memory read port),
//        vMem* (vmem read/write port), tile* / weightData / vmemData (to tile),
//        vmemOut / spikeBuffer (from tile), spikeOut / busy / done (status).
module tile_event_sequencer
  import snn_pkg::*;
#(
  parameter int size_data    = default_size_data,
  parameter int size_vmem    = default_size_vmem,
  parameter int size_tile    = default_size_tile,
  parameter int num_inputs   = default_num_inputs,
  parameter int size_addr    = default_size_addr,
  parameter int tile_latency = default_tile_latency
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [num_inputs-1:0]         inSpikes,
  input  logic [size_addr-1:0]          weightBase,
  input  logic [size_addr-1:0]          vmemAddr,
  output logic                          wMemRe,
  output logic [size_addr-1:0]          wMemAddr,
  input  logic [size_tile*size_data-1:0] wMemData,
  output logic                          vMemRe,
  output logic                          vMemWe,
  output logic [size_addr-1:0]          vMemAddrOut,
  input  logic [size_tile*size_vmem-1:0] vMemRdata,
  output logic [size_tile*size_vmem-1:0] vMemWdata,
  output logic                          tileEnable,
  output logic                          tileMemReady,
  output logic                          tileFinished,
  output logic [size_tile*size_data-1:0] weightData,
  output logic [size_tile*size_vmem-1:0] vmemData,
  input  logic [size_tile*size_vmem-1:0] vmemOut,
  input  logic                          spikeBuffer,
  output logic                          spikeOut,
  output logic                          busy,
  output logic                          done
);

  localparam int wword_w = size_tile * size_data;
  localparam int idx_w   = (num_inputs > 1) ? $clog2(num_inputs) : 1;
  localparam int cnt_w   = (tile_latency > 1) ? $clog2(tile_latency) : 1;

  seq_state_t              state;
  logic [num_inputs-1:0]   mask_q;
  logic [size_addr-1:0]    base_q;
  logic [size_addr-1:0]    vaddr_q;
  logic [cnt_w-1:0]        wait_cnt;
  logic [wword_w-1:0]      weight_q;

  logic [idx_w-1:0]        enc_idx;
  logic                    enc_vld;

  lowest_set_encoder #(
    .width (num_inputs),
    .idx_w (idx_w)
  ) u_enc (
    .vec   (mask_q),
    .idx   (enc_idx),
    .valid (enc_vld)
  );

  // Weight read data arrives during W_VALID, the same cycle memReady is high,
  // so the tile sees it through a bypass; weight_q holds it afterwards.
  assign weightData = (state == W_VALID) ? wMemData : weight_q;

  // The fetch for the lowest pending bit is issued on entry to SCAN so that
  // wMemRe/wMemAddr are registered and high exactly during SCAN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      mask_q       <= '0;
      base_q       <= '0;
      vaddr_q      <= '0;
      wait_cnt     <= '0;
      weight_q     <= '0;
      wMemRe       <= 1'b0;
      wMemAddr     <= '0;
      vMemRe       <= 1'b0;
      vMemWe       <= 1'b0;
      vMemAddrOut  <= '0;
      vMemWdata    <= '0;
      tileEnable   <= 1'b0;
      tileMemReady <= 1'b0;
      tileFinished <= 1'b0;
      vmemData     <= '0;
      spikeOut     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mask_q      <= inSpikes;
            base_q      <= weightBase;
            vaddr_q     <= vmemAddr;
            vMemRe      <= 1'b1;
            vMemAddrOut <= vmemAddr;
            busy        <= 1'b1;
            state       <= RD_VMEM;
          end
        end

        RD_VMEM: begin
          vMemRe      <= 1'b0;
          vMemAddrOut <= '0;
          tileEnable  <= 1'b1;
          state       <= LATCH_VMEM;
        end

        LATCH_VMEM: begin
          vmemData <= vMemRdata;
          wMemRe   <= enc_vld;
          wMemAddr <= enc_vld ? base_q + size_addr'(enc_idx) : '0;
          state    <= SCAN;
        end

        SCAN: begin
          wMemRe <= 1'b0;
          if (enc_vld) begin
            mask_q[enc_idx] <= 1'b0;
            tileMemReady    <= 1'b1;
            state           <= W_VALID;
          end else begin
            wMemAddr     <= '0;
            tileFinished <= 1'b1;
            state        <= FINISH;
          end
        end

        W_VALID: begin
          weight_q     <= wMemData;
          tileMemReady <= 1'b0;
          // mask_q already has the fetched bit cleared here.
          wMemRe       <= enc_vld;
          wMemAddr     <= enc_vld ? base_q + size_addr'(enc_idx) : '0;
          state        <= SCAN;
        end

        FINISH: begin
          tileFinished <= 1'b0;
          wait_cnt     <= cnt_w'(tile_latency - 1);
          state        <= WAIT_TILE;
        end

        WAIT_TILE: begin
          if (wait_cnt == '0) begin
            // Tile outputs are valid by the last wait cycle; register them
            // so the write is presented cleanly during WRITEBACK.
            vMemWe      <= 1'b1;
            vMemAddrOut <= vaddr_q;
            vMemWdata   <= vmemOut;
            state       <= WRITEBACK;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        WRITEBACK: begin
          vMemWe      <= 1'b0;
          vMemAddrOut <= '0;
          vMemWdata   <= '0;
          spikeOut    <= spikeBuffer;
          tileEnable  <= 1'b0;
          done        <= 1'b1;
          state       <= DONE;
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_event_sequencer.sv
module tb_tile_event_sequencer;

  logic         clk;
  logic         reset;
  logic         start;
  logic [15:0]  inSpikes;
  logic [7:0]   weightBase;
  logic [7:0]   vmemAddr;
  logic         wMemRe;
  logic [7:0]   wMemAddr;
  logic [31:0]  wMemData;
  logic         vMemRe;
  logic         vMemWe;
  logic [7:0]   vMemAddrOut;
  logic [63:0]  vMemRdata;
  logic [63:0]  vMemWdata;
  logic         tileEnable;
  logic         tileMemReady;
  logic         tileFinished;
  logic [31:0]  weightData;
  logic [63:0]  vmemData;
  logic [63:0]  vmemOut;
  logic         spikeBuffer;
  logic         spikeOut;
  logic         busy;
  logic         done;

  localparam logic [63:0] VRD = 64'h0001_0002_0003_0004;

  int n_checks = 0;
  int n_err    = 0;

  tile_event_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .inSpikes     (inSpikes),
    .weightBase   (weightBase),
    .vmemAddr     (vmemAddr),
    .wMemRe       (wMemRe),
    .wMemAddr     (wMemAddr),
    .wMemData     (wMemData),
    .vMemRe       (vMemRe),
    .vMemWe       (vMemWe),
    .vMemAddrOut  (vMemAddrOut),
    .vMemRdata    (vMemRdata),
    .vMemWdata    (vMemWdata),
    .tileEnable   (tileEnable),
    .tileMemReady (tileMemReady),
    .tileFinished (tileFinished),
    .weightData   (weightData),
    .vmemData     (vmemData),
    .vmemOut      (vmemOut),
    .spikeBuffer  (spikeBuffer),
    .spikeOut     (spikeOut),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight memory contents: distinct pattern per address.
  function automatic logic [31:0] wfn(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  // Synchronous memories, one-cycle read latency.
  always @(posedge clk) begin
    if (wMemRe) wMemData <= wfn(wMemAddr);
    if (vMemRe) vMemRdata <= VRD;
  end

  // Observation of DUT traffic, sampled mid-cycle.
  logic [7:0]  fetch_q[$];
  logic [31:0] rdy_q[$];
  int          wr_cnt, rd_cnt, done_cnt, overlap_cnt;
  logic [7:0]  wr_addr, rd_addr;
  logic [63:0] wr_data;
  logic        so_at_wb;

  always @(negedge clk) begin
    if (wMemRe) fetch_q.push_back(wMemAddr);
    if (tileMemReady) rdy_q.push_back(weightData);
    if (vMemRe) begin rd_cnt++; rd_addr = vMemAddrOut; end
    if (vMemWe) begin wr_cnt++; wr_addr = vMemAddrOut; wr_data = vMemWdata; so_at_wb = spikeOut; end
    if (vMemRe && vMemWe) overlap_cnt++;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    fetch_q.delete();
    rdy_q.delete();
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0;
  endtask

  // One timestep; dcyc = cycle (after the start-sampling edge) in which done is high, -1 on timeout.
  task automatic run_ts(input logic [15:0] spk, input logic [7:0] wb, input logic [7:0] va,
                        input int glitch_at, output int dcyc);
    clear_obs();
    dcyc = -1;
    @(negedge clk);
    inSpikes = spk; weightBase = wb; vmemAddr = va; start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) begin start = 1'b0; inSpikes = 16'h0; weightBase = 8'h00; end
      if (c == glitch_at) begin start = 1'b1; inSpikes = 16'hFFFF; weightBase = 8'h80; end
      else if (c == glitch_at + 1) start = 1'b0;
      if (done) begin dcyc = c; break; end
    end
    @(negedge clk);
  endtask

  logic [184:0] all_outs;
  assign all_outs = {wMemRe, wMemAddr, vMemRe, vMemWe, vMemAddrOut, vMemWdata, tileEnable,
                     tileMemReady, tileFinished, weightData, vmemData, spikeOut, busy, done};

  int d;

  initial begin
    reset = 1'b0; start = 1'b0; inSpikes = '0; weightBase = '0; vmemAddr = '0;
    vmemOut = 64'hDEAD_BEEF_0123_4567; spikeBuffer = 1'b0;
    wMemData = '0; vMemRdata = '0; overlap_cnt = 0;
    #2;
    check("reset_outputs_zero", 64'(|all_outs), 64'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    // Zero spikes
    run_ts(16'h0000, 8'h10, 8'h33, -1, d);
    check("k0_done_cycle", 64'(d), 64'd8);
    check("k0_no_fetch", 64'(fetch_q.size()), 64'd0);
    check("k0_no_memready", 64'(rdy_q.size()), 64'd0);
    check("k0_vmem_reads", 64'(rd_cnt), 64'd1);
    check("k0_vmem_rd_addr", 64'(rd_addr), 64'h33);
    check("k0_vmemData", vmemData, VRD);
    check("k0_writes", 64'(wr_cnt), 64'd1);
    check("k0_wr_addr", 64'(wr_addr), 64'h33);
    check("k0_wr_data", wr_data, 64'hDEAD_BEEF_0123_4567);
    check("k0_done_pulses", 64'(done_cnt), 64'd1);
    check("k0_busy_after", 64'(busy), 64'd0);
    check("k0_tileEnable_after", 64'(tileEnable), 64'd0);

    // Three spikes, with spikeBuffer high at writeback
    spikeBuffer = 1'b1;
    vmemOut = 64'h1111_2222_3333_4444;
    run_ts(16'h8005, 8'h10, 8'h07, -1, d);
    check("k3_done_cycle", 64'(d), 64'd14);
    check("k3_fetch_count", 64'(fetch_q.size()), 64'd3);
    check("k3_fetch0", 64'(fetch_q[0]), 64'h10);
    check("k3_fetch1", 64'(fetch_q[1]), 64'h12);
    check("k3_fetch2", 64'(fetch_q[2]), 64'h1F);
    check("k3_memready_count", 64'(rdy_q.size()), 64'd3);
    check("k3_wdata0", 64'(rdy_q[0]), 64'(wfn(8'h10)));
    check("k3_wdata1", 64'(rdy_q[1]), 64'(wfn(8'h12)));
    check("k3_wdata2", 64'(rdy_q[2]), 64'(wfn(8'h1F)));
    check("k3_wr_data", wr_data, 64'h1111_2222_3333_4444);
    check("k3_weight_held", 64'(weightData), 64'(wfn(8'h1F)));
    check("k3_spikeOut", 64'(spikeOut), 64'd1);

    // All spikes, address wrap; spikeOut stays 1 until this writeback
    spikeBuffer = 1'b0;
    run_ts(16'hFFFF, 8'hF8, 8'h02, -1, d);
    check("all_done_cycle", 64'(d), 64'd40);
    check("all_fetch_count", 64'(fetch_q.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < fetch_q.size()) check($sformatf("all_fetch%0d", i), 64'(fetch_q[i]), 64'((8'hF8 + i) & 8'hFF));
    end
    check("all_memready_count", 64'(rdy_q.size()), 64'd16);
    check("all_spikeOut_at_wb", 64'(so_at_wb), 64'd1);
    check("all_spikeOut_after", 64'(spikeOut), 64'd0);

    // Start pulsed during SCAN with a different spike vector
    run_ts(16'h8005, 8'h10, 8'h07, 3, d);
    check("glitch_done_cycle", 64'(d), 64'd14);
    check("glitch_fetch_count", 64'(fetch_q.size()), 64'd3);
    if (fetch_q.size() == 3) begin
      check("glitch_fetch0", 64'(fetch_q[0]), 64'h10);
      check("glitch_fetch2", 64'(fetch_q[2]), 64'h1F);
    end
    check("glitch_no_restart", 64'(busy), 64'd0);

    // Reset during W_VALID
    clear_obs();
    @(negedge clk);
    inSpikes = 16'h8005; weightBase = 8'h10; vmemAddr = 8'h07; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_w_valid", 64'(tileMemReady), 64'd1);
    #1 reset = 1'b0;
    #1 check("rst_async_zero", 64'(|all_outs), 64'd0);
    repeat (3) @(negedge clk);
    check("rst_no_write", 64'(wr_cnt), 64'd0);
    check("rst_no_done", 64'(done_cnt), 64'd0);
    reset = 1'b1;
    run_ts(16'h0002, 8'h40, 8'h21, -1, d);
    check("post_rst_done_cycle", 64'(d), 64'd10);
    check("post_rst_fetch", 64'(fetch_q.size() == 1 ? fetch_q[0] : 8'hXX), 64'h41);
    check("post_rst_wr_addr", 64'(wr_addr), 64'h21);

    // Start held high through DONE
    clear_obs();
    @(negedge clk);
    inSpikes = 16'h0000; weightBase = 8'h00; vmemAddr = 8'h55; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 8) check("held_done_c8", 64'(done), 64'd1);
      if (c == 9) check("held_idle_c9", 64'(busy), 64'd0);
      if (c == 10) begin
        check("held_restart_busy", 64'(busy), 64'd1);
        check("held_restart_vMemRe", 64'(vMemRe), 64'd1);
        start = 1'b0;
      end
    end
    d = -1;
    for (int c = 11; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin d = c; break; end
    end
    check("held_second_done", 64'(d), 64'd17);
    check("held_writes", 64'(wr_cnt), 64'd2);

    check("no_rd_wr_overlap", 64'(overlap_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/tile_event_sequencer.md
Name: tile_event_sequencer

Overview:
- Upstream control stage for one neuron_tile: per timestep it loads the tile's membrane potentials from vmem memory and walks the presynaptic spike vector.
- For each active input it fetches the matching weight row from weight memory and presents it to the tile with a one-cycle memReady strobe.
- It then signals finished, waits for the tile pipeline to drain, writes vmemOut back to vmem memory and captures spikeBuffer.
- One instance sits between the layer controller/memories and each neuron_tile.

Parameters:
- size_data, 8, weight width per neuron
- size_vmem, 16, membrane potential width per neuron
- size_tile, 4, neurons per tile
- num_inputs, 16, presynaptic spike vector width
- size_addr, 8, memory address width
- tile_latency, 2, cycles from tileFinished until vmemOut/spikeBuffer are valid (min 1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin timestep; sampled only in IDLE
- inSpikes  in  num_inputs  presynaptic spikes, captured on start
- weightBase  in  size_addr  weight row address for input 0, captured on start
- vmemAddr  in  size_addr  vmem word address for this tile, captured on start
- wMemRe  out  1  weight memory read enable
- wMemAddr  out  size_addr  weight memory address
- wMemData  in  size_tile*size_data  weight read data, valid 1 cycle after wMemRe
- vMemRe  out  1  vmem read enable
- vMemWe  out  1  vmem write enable
- vMemAddrOut  out  size_addr  vmem address
- vMemRdata  in  size_tile*size_vmem  vmem read data, valid 1 cycle after vMemRe
- vMemWdata  out  size_tile*size_vmem  vmem write data
- tileEnable  out  1  to tile enable
- tileMemReady  out  1  to tile memReady; weightData valid
- tileFinished  out  1  to tile finished
- weightData  out  size_tile*size_data  to tile weightData
- vmemData  out  size_tile*size_vmem  to tile vmemData
- vmemOut  in  size_tile*size_vmem  from tile vmemOut
- spikeBuffer  in  1  from tile spikeBuffer
- spikeOut  out  1  spikeBuffer captured at writeback
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of timestep

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0, including weightData, vmemData, vMemWdata and spikeOut; pending mask cleared.
- FSM states, one cycle each unless noted:
  - IDLE: on start=1, latch inSpikes into the pending mask and latch weightBase and vmemAddr; go to RD_VMEM.
  - RD_VMEM: vMemRe=1, vMemAddrOut=vmemAddr latch; go to LATCH_VMEM.
  - LATCH_VMEM: vmemData<=vMemRdata, held for the whole timestep; tileEnable rises.
  - SCAN: if the pending mask is 0, go to FINISH. Otherwise take idx = lowest set bit, set wMemRe=1 and wMemAddr=weightBase+idx (modulo 2^size_addr, wrap allowed), clear that bit, and go to W_VALID.
  - W_VALID: weightData<=wMemData with tileMemReady=1 in the same cycle; go to SCAN.
  - FINISH: tileFinished=1; go to WAIT_TILE.
  - WAIT_TILE: tile_latency cycles, counted down; then go to WRITEBACK.
  - WRITEBACK: vMemWe=1, vMemAddrOut=vmemAddr latch, vMemWdata=vmemOut, spikeOut<=spikeBuffer; go to DONE.
  - DONE: done=1, tileEnable=0; go to IDLE.
- tileEnable is high from LATCH_VMEM through WRITEBACK.
- Strobes (wMemRe, vMemRe, vMemWe, tileMemReady, tileFinished, done) are high only in their named state.
- vMemRe and vMemWe are never high together.
- Latency: with k set spikes, done is high in cycle 6+2k+tile_latency after the start-sampling edge.
- Inputs are processed in ascending index order; each set bit is fetched exactly once.
- Boundary cases:
  - start while busy: ignored, and inSpikes changes are not seen.
  - k=0: no wMemRe and no tileMemReady; vmem is still read and written back.
  - All bits set: num_inputs fetches.
  - weightBase+idx overflow: wraps.
  - start held high through DONE: a new timestep begins on the IDLE cycle that follows.
  - Reset mid-operation: immediate return to IDLE; no write is issued and done does not pulse.

Decomposition:
- Package snn_pkg:
  - state enum (IDLE, RD_VMEM, LATCH_VMEM, SCAN, W_VALID, FINISH, WAIT_TILE, WRITEBACK, DONE)
  - width constants for the weight word (size_tile*size_data) and the vmem word (size_tile*size_vmem)
- Sub-module lowest_set_encoder (num_inputs in; index and valid out), combinational, reused by later layer-level schedulers.

Test Plan:
- Zero spikes, tile_latency=2, vMemRdata=0x0001_0002_0003_0004: no wMemRe; done in cycle 8; vMemWe once, at vmemAddr, with vmemOut value.
- inSpikes=16'h8005, weightBase=0x10: wMemAddr sequence 0x10, 0x12, 0x1F; three tileMemReady pulses, each carrying the matching wMemData; done in cycle 14.
- inSpikes=16'hFFFF, weightBase=0xF8: 16 fetches, addresses wrap 0xF8..0xFF then 0x00..0x07; done in cycle 40.
- start pulsed during SCAN with different inSpikes: ignored; fetch sequence and done timing unchanged.
- Reset asserted during W_VALID: all outputs 0 asynchronously; no vMemWe; after release, a fresh start completes normally.
- spikeBuffer=1 at WRITEBACK: spikeOut=1 from the next cycle until the next WRITEBACK or reset.
